// File: rtl/programmable_clock_divider.sv
// Runtime-programmable clock divider with even/odd divisors and edge strobes.
// Divisor changes take effect only at the falling edge of o_div_clock.
//
// Ports:
//   i_clock      system clock, all logic on its rising edge
//   i_reset      synchronous reset, active high
//   i_enable     count enable; low freezes the divider
//   i_divisor    requested divide ratio D (WIDTH bits)
//   i_load       strobe: capture i_divisor as the pending divisor
//   o_div_clock  divided clock (registered)
//   o_rise_tick  one-cycle strobe in the first cycle o_div_clock reads 1
//   o_fall_tick  one-cycle strobe in the first cycle o_div_clock reads 0
//   o_pending    a loaded divisor is waiting for the next period boundary
module programmable_clock_divider #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_load,
  output logic             o_div_clock,
  output logic             o_rise_tick,
  output logic             o_fall_tick,
  output logic             o_pending
);

  if (RESET_DIV < 2 ||
      (WIDTH < 31 && RESET_DIV >= (1 << WIDTH))) begin : g_bad_reset_div
    $error("RESET_DIV must be >= 2 and < 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] RESET_D = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  logic [WIDTH-1:0] low_len;
  logic [WIDTH-1:0] high_len;
  logic             low_end;
  logic             high_end;
  logic             boundary;
  logic [WIDTH-1:0] load_val;

  // Odd divisors put the extra cycle in the high phase.
  assign low_len  = div_q >> 1;
  assign high_len = div_q - low_len;
  assign low_end  = (cnt_q == low_len - ONE);
  assign high_end = (cnt_q == high_len - ONE);
  assign boundary = i_enable && (state_q == ST_HIGH) && high_end;
  assign load_val = (i_divisor < TWO) ? TWO : i_divisor;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      div_q   <= RESET_D;
      pdiv_q  <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_enable) begin
      unique case (state_q)
        ST_LOW: begin
          if (low_end) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_HIGH: begin
          if (high_end) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      endcase
    end
  end

  // Output logic (registered outputs, ticks default low)
  always_comb begin
    clk_d  = clk_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (i_enable) begin
      if (state_q == ST_LOW && low_end) begin
        clk_d  = 1'b1;
        rise_d = 1'b1;
      end
      if (state_q == ST_HIGH && high_end) begin
        clk_d  = 1'b0;
        fall_d = 1'b1;
      end
    end
  end

  // Divisor load/apply. A load in the boundary cycle bypasses the
  // pending register so the next low phase already uses it.
  always_comb begin
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    if (boundary) begin
      if (i_load) begin
        div_d  = load_val;
        pend_d = 1'b0;
      end else if (pend_q) begin
        div_d  = pdiv_q;
        pend_d = 1'b0;
      end
    end else if (i_load) begin
      pdiv_d = load_val;
      pend_d = 1'b1;
    end
  end

  assign o_div_clock = clk_q;
  assign o_rise_tick = rise_q;
  assign o_fall_tick = fall_q;
  assign o_pending   = pend_q;

endmodule
